// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU.
// Holds the opcode encodings, the sequencer state type and the default datapath width.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // True for opcodes that run through the iterative unit
    function automatic logic is_iter(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative unsigned multiply (shift-add) and divide (restoring) datapath.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   load         : capture operands a/b and the mode (is_div)
//   step         : perform one iteration
//   is_div       : 1 = divide a/b, 0 = multiply a*b (sampled on load)
//   a, b         : operands
//   hi, lo       : accumulator value as it will be after this cycle (look-ahead),
//                  so the caller can register the final result on the last step.
//                  Multiply: {hi,lo} = product. Divide: lo = quotient, hi = remainder.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic [WIDTH-1:0] hi_n, lo_n, opnd_n;
    logic             div_q, div_n;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             fits;

    // Next accumulator value: operand load or one multiply/divide iteration
    always_comb begin
        hi_n   = hi_q;
        lo_n   = lo_q;
        opnd_n = opnd_q;
        div_n  = div_q;

        add_sum = {1'b0, hi_q} + {1'b0, opnd_q};
        shifted = {hi_q, lo_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, opnd_q});
        // When fits, the true difference is below the divisor, so WIDTH bits suffice
        trial   = shifted[WIDTH-1:0] - opnd_q;

        if (load) begin
            hi_n   = '0;
            lo_n   = is_div ? a : b;
            opnd_n = is_div ? b : a;
            div_n  = is_div;
        end else if (step) begin
            if (div_q) begin
                // A zero divisor always fits: quotient ends all ones, remainder ends as the dividend
                hi_n = fits ? trial : shifted[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], fits};
            end else if (lo_q[0]) begin
                {hi_n, lo_n} = {add_sum, lo_q[WIDTH-1:1]};
            end else begin
                {hi_n, lo_n} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
        end
    end

    // Accumulator registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
        end else begin
            hi_q   <= hi_n;
            lo_q   <= lo_n;
            opnd_q <= opnd_n;
            div_q  <= div_n;
        end
    end

    assign hi = hi_n;
    assign lo = lo_n;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arithmetic ops complete one cycle after accept; MULU/DIVU take WIDTH+1.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   in_valid / in_ready   : operation handshake (alu_op, src1, src2)
//   out_valid / out_ready : result handshake
//   result_lo, result_hi  : result (product low/high, quotient/remainder)
//   zero, carry, overflow : flags; err flags illegal op or divide by zero
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             accept, load, step, last;
    logic             div_zero_q;

    logic [WIDTH-1:0] iter_hi, iter_lo;

    logic             sub_mode, c_out, c_msb, ovf;
    logic [WIDTH-1:0] b_eff, sum;
    logic [WIDTH-1:0] alu_lo;
    logic             alu_c, alu_v, alu_e;

    // Single-cycle ALU on the incoming operands; SLT reuses the subtractor
    always_comb begin
        sub_mode     = (alu_op == OP_SUB) || (alu_op == OP_SLT);
        b_eff        = sub_mode ? ~src2 : src2;
        {c_out, sum} = {1'b0, src1} + {1'b0, b_eff} + (WIDTH+1)'(sub_mode);
        c_msb        = src1[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
        ovf          = c_msb ^ c_out;

        alu_lo = '0;
        alu_c  = 1'b0;
        alu_v  = 1'b0;
        alu_e  = 1'b0;
        case (alu_op)
            OP_AND:  alu_lo = src1 & src2;
            OP_OR:   alu_lo = src1 | src2;
            OP_NOR:  alu_lo = ~(src1 | src2);
            OP_ADD, OP_SUB: begin
                alu_lo = sum;
                alu_c  = c_out;
                alu_v  = ovf;
            end
            // Sign of the true difference, valid even when the subtraction overflows
            OP_SLT:  alu_lo = WIDTH'(sum[WIDTH-1] ^ ovf);
            OP_MULU, OP_DIVU: alu_lo = '0;
            default: alu_e = 1'b1;
        endcase
    end

    // Sequencer next state and control strobes
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        accept  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept = 1'b1;
                    if (is_iter(alu_op)) begin
                        load    = 1'b1;
                        cnt_n   = '0;
                        state_n = CALC;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    last    = 1'b1;
                    cnt_n   = '0;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and iteration counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // Handshake and result registers; results change only when entering DONE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            result_lo  <= '0;
            result_hi  <= '0;
            zero       <= 1'b0;
            carry      <= 1'b0;
            overflow   <= 1'b0;
            err        <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == DONE);
            if (accept) begin
                div_zero_q <= (alu_op == OP_DIVU) && (src2 == '0);
                if (!is_iter(alu_op)) begin
                    result_lo <= alu_lo;
                    result_hi <= '0;
                    zero      <= (alu_lo == '0);
                    carry     <= alu_c;
                    overflow  <= alu_v;
                    err       <= alu_e;
                end
            end
            if (last) begin
                result_lo <= iter_lo;
                result_hi <= iter_hi;
                zero      <= (iter_lo == '0);
                carry     <= 1'b0;
                overflow  <= 1'b0;
                err       <= div_zero_q;
            end
        end
    end

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load   (load),
        .step   (step),
        .is_div (alu_op == OP_DIVU),
        .a      (src1),
        .b      (src2),
        .hi     (iter_hi),
        .lo     (iter_lo)
    );

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32 plus a WIDTH=8 instance), scoreboard of expected results.
module tb_alu_seq;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         z;
        logic         c;
        logic         v;
        logic         e;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   alu_op = 4'b0;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic         in_ready, out_valid, zero, carry, overflow, err;
    logic [W-1:0] result_lo, result_hi;

    logic         in_valid8 = 1'b0;
    logic         out_ready8 = 1'b0;
    logic [3:0]   alu_op8 = 4'b0;
    logic [7:0]   src1_8 = '0;
    logic [7:0]   src2_8 = '0;
    logic         in_ready8, out_valid8, zero8, carry8, overflow8, err8;
    logic [7:0]   lo8, hi8;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t last_exp;

    alu_seq #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .src1(src1), .src2(src2), .out_valid(out_valid),
        .out_ready(out_ready), .result_lo(result_lo), .result_hi(result_hi),
        .zero(zero), .carry(carry), .overflow(overflow), .err(err)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .alu_op(alu_op8), .src1(src1_8), .src2(src2_8), .out_valid(out_valid8),
        .out_ready(out_ready8), .result_lo(lo8), .result_hi(hi8),
        .zero(zero8), .carry(carry8), .overflow(overflow8), .err(err8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference behaviour written from the arithmetic definitions
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         r;
        logic [W:0]   s;
        logic [2*W-1:0] p;
        r = '{default: '0};
        case (op)
            4'b0000: r.lo = a & b;
            4'b0001: r.lo = a | b;
            4'b1100: r.lo = ~(a | b);
            4'b0010: begin
                s    = {1'b0, a} + {1'b0, b};
                r.lo = s[W-1:0];
                r.c  = s[W];
                r.v  = (a[W-1] == b[W-1]) && (r.lo[W-1] != a[W-1]);
            end
            4'b0110: begin
                r.lo = a - b;
                r.c  = (a >= b);
                r.v  = (a[W-1] != b[W-1]) && (r.lo[W-1] != a[W-1]);
            end
            4'b0111: r.lo = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'b1000: begin
                p    = (2*W)'(a) * (2*W)'(b);
                r.lo = p[W-1:0];
                r.hi = p[2*W-1:W];
            end
            4'b1001: begin
                if (b == '0) begin
                    r.lo = '1;
                    r.hi = a;
                    r.e  = 1'b1;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
            default: r.e = 1'b1;
        endcase
        r.z = (r.lo == '0);
        return r;
    endfunction

    // Called at a negedge; returns at the first negedge after the accept edge
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        alu_op   = op;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        sb.push_back(model(op, a, b));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for out_valid, checks latency (cycles after accept) and the result
    task automatic collect(input string tag, input int exp_lat, input bit busy);
        int   lat = 1;
        logic busy_ok = 1'b1;
        exp_t e;
        while (!out_valid && lat < 200) begin
            if (busy && in_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        if (busy) chk({tag, "_in_ready_busy"}, 64'(busy_ok), 64'd1);
        chk({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard"}, 64'd0, 64'd1);
        end else begin
            e        = sb.pop_front();
            last_exp = e;
            chk({tag, "_lo"}, 64'(result_lo), 64'(e.lo));
            chk({tag, "_hi"}, 64'(result_hi), 64'(e.hi));
            chk({tag, "_flags"}, 64'({zero, carry, overflow, err}), 64'({e.z, e.c, e.v, e.e}));
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [3:0] ops[6];
        logic       stable;
        logic       quiet;
        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b1100;
        ops[3] = 4'b0010; ops[4] = 4'b0110; ops[5] = 4'b0111;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_results", {result_hi, result_lo}, 64'd0);
        chk("rst_flags", 64'({zero, carry, overflow, err}), 64'd0);

        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        collect("add_ovf", 1, 1'b0);
        chk("add_ovf_lo_const", 64'(result_lo), 64'h8000_0000);
        chk("add_ovf_cv_const", 64'({carry, overflow}), 64'b01);
        release_out("add_ovf");

        issue(4'b0110, 32'd5, 32'd5);
        collect("sub_eq", 1, 1'b0);
        chk("sub_eq_const", 64'({zero, carry, overflow}), 64'b110);
        release_out("sub_eq");

        issue(4'b0111, 32'h8000_0000, 32'h0000_0001);
        collect("slt_ovf", 1, 1'b0);
        chk("slt_ovf_const", 64'(result_lo), 64'd1);
        release_out("slt_ovf");

        issue(4'b0111, 32'h0000_0001, 32'h8000_0000);
        collect("slt_swap", 1, 1'b0);
        release_out("slt_swap");

        for (int i = 0; i < 12; i++) begin
            issue(ops[i % 6], $urandom, $urandom);
            collect("single_rand", 1, 1'b0);
            release_out("single_rand");
        end

        issue(4'b0011, 32'h1234, 32'h5678);
        collect("illegal", 1, 1'b0);
        release_out("illegal");

        issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        collect("mulu_max", 33, 1'b1);
        chk("mulu_max_const", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);
        release_out("mulu_max");

        issue(4'b1001, 32'd100, 32'd7);
        collect("divu", 33, 1'b1);
        chk("divu_const", {result_hi, result_lo}, {32'd2, 32'd14});
        release_out("divu");

        issue(4'b1001, 32'd9, 32'd0);
        collect("divu_zero", 33, 1'b1);
        chk("divu_zero_const", 64'({err, result_hi, result_lo}), {31'd0, 1'b1, 32'd9, 32'hFFFF_FFFF});
        release_out("divu_zero");

        for (int i = 0; i < 4; i++) begin
            issue((i % 2 == 0) ? 4'b1000 : 4'b1001, $urandom, $urandom_range(1, 1000));
            collect("iter_rand", 33, 1'b1);
            release_out("iter_rand");
        end

        // Stall in DONE with a competing request that must be ignored
        issue(4'b1000, 32'h1234_5678, 32'h9ABC_DEF0);
        collect("hold", 33, 1'b1);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            alu_op   = 4'b0010;
            src1     = $urandom;
            src2     = $urandom;
            @(negedge clk);
            if (!out_valid || in_ready || result_lo !== last_exp.lo || result_hi !== last_exp.hi)
                stable = 1'b0;
        end
        in_valid = 1'b0;
        chk("hold_stable", 64'(stable), 64'd1);
        release_out("hold");
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) quiet = 1'b0;
        end
        chk("hold_no_extra_op", 64'(quiet), 64'd1);

        // Reset in the middle of an iterative op
        issue(4'b1000, 32'hDEAD_BEEF, 32'h0000_0003);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_front());
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_results", {result_hi, result_lo}, 64'd0);
        chk("midrst_flags", 64'({zero, carry, overflow, err}), 64'd0);
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) quiet = 1'b0;
        end
        chk("midrst_no_completion", 64'(quiet), 64'd1);

        // Same ADD overflow case on an 8-bit instance
        chk("w8_in_ready", 64'(in_ready8), 64'd1);
        alu_op8   = 4'b0010;
        src1_8    = 8'h7F;
        src2_8    = 8'h01;
        in_valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        chk("w8_out_valid", 64'(out_valid8), 64'd1);
        chk("w8_lo", 64'(lo8), 64'h80);
        chk("w8_hi", 64'(hi8), 64'h00);
        chk("w8_flags", 64'({zero8, carry8, overflow8, err8}), 64'b0010);
        out_ready8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready8 = 1'b0;
        chk("w8_release", 64'({out_valid8, in_ready8}), 64'b01);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
